// File: rtl/pea_pkg.sv
// Shared codes for the PEA firing scheduler: actor mode encodings, scheduler
// FSM states and sticky error codes.
package pea_pkg;

    typedef enum logic [1:0] {
        MODE_SETUP_INSTR = 2'b00,
        MODE_INSTR       = 2'b01,
        MODE_OUTPUT      = 2'b10,
        MODE_ILLEGAL     = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_INVOKE,
        ST_WAIT,
        ST_ERROR
    } sched_state_e;

    localparam logic [1:0] ERR_NONE       = 2'b00;
    localparam logic [1:0] ERR_FC_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_BAD_MODE   = 2'b10;

    function automatic logic is_legal_mode(input logic [1:0] mode);
        return mode != MODE_ILLEGAL;
    endfunction

endpackage

// File: rtl/pea_firing_scheduler_if.sv
// Scheduler <-> PEA actor handshake: firing strobe and mode out, enable,
// firing-complete and requested next mode back.
interface pea_firing_scheduler_if;
    logic       invoke;
    logic [1:0] next_instr;
    logic       enable_in;
    logic       fc_in;
    logic [1:0] next_mode_in;

    modport master (
        output invoke,
        output next_instr,
        input  enable_in,
        input  fc_in,
        input  next_mode_in
    );

    modport slave (
        input  invoke,
        input  next_instr,
        output enable_in,
        output fc_in,
        output next_mode_in
    );
endinterface

// File: rtl/pea_watchdog.sv
// Clear/count/expire counter: expire is high on the LIMIT-th consecutive
// counted cycle since the last clear; the count holds once expired.
module pea_watchdog #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expire
);
    localparam int           W    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign expire = (cnt_q == LAST);

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count && !expire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/pea_firing_scheduler.sv
// Self-timed CFDF scheduler for the PEA actor: presents the mode, samples enable,
// strobes invoke, awaits a fresh FC edge and adopts the actor's next mode.
module pea_firing_scheduler
    import pea_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int MAX_FIRINGS  = 0,
    parameter int TIMEOUT      = 1024,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    halt,
    pea_firing_scheduler_if.master  act,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              err_code,
    output logic [CNT_W-1:0]        fire_count
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_FIRINGS);
    localparam bit               LIMITED = (MAX_FIRINGS != 0);

    sched_state_e     state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       err_q, err_d;
    logic             done_q, done_d;
    logic             halt_q, halt_d;
    logic             fc_q;

    logic             fc_edge;
    logic             busy_w;
    logic [CNT_W-1:0] fire_inc;
    logic             wd_clr, wd_cnt, wd_exp;
    logic             starve_clr, starve_cnt, starve_exp;

    // Only a rising FC seen while waiting completes a firing; a level left high is stale.
    assign fc_edge  = act.fc_in & ~fc_q;
    assign busy_w   = (state_q == ST_CHECK) || (state_q == ST_INVOKE) || (state_q == ST_WAIT);
    assign fire_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    pea_watchdog #(.LIMIT(TIMEOUT)) u_fc_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clr),
        .count  (wd_cnt),
        .expire (wd_exp)
    );

    pea_watchdog #(.LIMIT(STARVE_LIMIT)) u_starve_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (starve_clr),
        .count  (starve_cnt),
        .expire (starve_exp)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        done_d     = 1'b0;
        halt_d     = halt_q | (busy_w & halt);
        wd_clr     = 1'b0;
        wd_cnt     = 1'b0;
        starve_clr = 1'b0;
        starve_cnt = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_ERROR: begin
                // A start coinciding with the done pulse belongs to the finished run.
                if (start && !done_q) begin
                    state_d    = ST_CHECK;
                    mode_d     = MODE_SETUP_INSTR;
                    cnt_d      = '0;
                    err_d      = ERR_NONE;
                    halt_d     = halt;
                    starve_clr = 1'b1;
                end
            end
            ST_CHECK: begin
                if (halt_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (act.enable_in) begin
                    state_d    = ST_INVOKE;
                    starve_clr = 1'b1;
                end else if (starve_exp) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    starve_cnt = 1'b1;
                end
            end
            ST_INVOKE: begin
                state_d = ST_WAIT;
                wd_clr  = 1'b1;
            end
            ST_WAIT: begin
                // An FC edge beats a watchdog expiring in the same cycle.
                if (fc_edge) begin
                    cnt_d = fire_inc;
                    if (!is_legal_mode(act.next_mode_in)) begin
                        err_d   = ERR_BAD_MODE;
                        state_d = ST_ERROR;
                    end else begin
                        mode_d = act.next_mode_in;
                        if (LIMITED && fire_inc == MAX_CNT) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_CHECK;
                        end
                    end
                end else if (wd_exp) begin
                    err_d   = ERR_FC_TIMEOUT;
                    state_d = ST_ERROR;
                end else begin
                    wd_cnt = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_SETUP_INSTR;
            cnt_q   <= '0;
            err_q   <= ERR_NONE;
            done_q  <= 1'b0;
            halt_q  <= 1'b0;
            fc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
            halt_q  <= halt_d;
            fc_q    <= act.fc_in;
        end
    end

    assign act.invoke     = (state_q == ST_INVOKE);
    assign act.next_instr = mode_q;
    assign busy           = busy_w;
    assign done           = done_q;
    assign err_code       = err_q;
    assign fire_count     = cnt_q;
endmodule
